servo_pwm_core: RTL and testbench
=================================

// Module: servo_pwm_core
// PURPOSE
//  Downstream stage of the AXI4-Lite servo register bank. Turns the latched enable/target/slew
//  register values into a frame-synchronous servo PWM: 1 us time base, fixed PERIOD_US frame.
//  Pulse width is clamped to [MIN_US, MAX_US] and slew-limited once per frame.
//  Drives the servo pin and returns cur_us/at_target to the bank for readback.
// PARAMETERS
//  CLK_FREQ_HZ  100_000_000  clk frequency; must be an integer multiple of 1_000_000
//  PERIOD_US    20000        frame length in us
//  MIN_US       500          lower pulse-width clamp
//  MAX_US       2500         upper pulse-width clamp
//  CENTER_US    1500         cur_us value after reset
//  PW_W         16           width of all us-valued ports
// PORTS
//  clk          in   1     ACLK of the IP
//  reset_p      in   1     asynchronous, active-high reset
//  enable       in   1     slv_reg0[0]; output enable
//  target_us    in   PW_W  slv_reg1; requested pulse width (us)
//  slew_us      in   PW_W  slv_reg2; max |change| of cur_us per frame; 0 = jump immediately
//  servo_pwm    out  1     servo pin, registered
//  cur_us       out  PW_W  pulse width in use this frame
//  at_target    out  1     cur_us == clamped target shadow
//  period_start out  1     1-clk pulse on each frame boundary
// BEHAVIOUR
//  Reset: all counters 0; en_sh=0; tgt_sh=CENTER_US; cur_us=CENTER_US.
//   Outputs at reset: servo_pwm=0, at_target=1, period_start=0. Async assert, sync release.
//  Tick: pre_cnt counts 0..CLK_FREQ_HZ/1e6-1; us_tick=1 on the terminal count (1 clk wide).
//  Frame: on us_tick, period_cnt counts 0..PERIOD_US-1 and wraps to 0.
//   boundary = us_tick && period_cnt==PERIOD_US-1.
//  At boundary edge:
//   - en_sh <= enable.
//   - tgt_sh <= clamp(target_us): target_us<MIN_US -> MIN_US; target_us>MAX_US -> MAX_US.
//   - cur_us <= slew(cur_us, clamp(target_us), slew_us).
//   - period_start <= 1 for exactly one clk.
//  Slew: diff = signed (PW_W+1)-bit target-cur.
//   - slew_us==0 or |diff|<=slew_us -> cur=target.
//   - otherwise cur +/- slew_us toward target. No overflow is possible.
//  Shadowing: enable/target/slew changes between boundaries have no effect until the next boundary.
//   A value present on the boundary clk itself is the one taken.
//  PWM: servo_pwm <= en_sh && (period_cnt < cur_us). One clk latency relative to the counters.
//   High time = cur_us*CLK_FREQ_HZ/1e6 clks exactly; period = PERIOD_US*CLK_FREQ_HZ/1e6 clks.
//  Enable: rising edge -> first pulse starts at the next boundary.
//   Falling edge mid-pulse -> pulse completes, then low from the next frame (no runt pulses).
//  at_target: combinational from registers; =1 while enable=0 if cur_us==tgt_sh.
//  Reset mid-pulse: servo_pwm drops to 0 immediately (async); the frame restarts from 0 after release.
//  Elaboration checks ($error):
//   - CLK_FREQ_HZ % 1_000_000 == 0
//   - MIN_US <= CENTER_US <= MAX_US < PERIOD_US
//   - PERIOD_US < 2**PW_W
// STRUCTURE
//  servo_pkg:
//   - default constants: CLK_FREQ_HZ, PERIOD_US, MIN_US, MAX_US, CENTER_US
//   - function clamp_us(val, lo, hi)
//   - function slew_step(cur, tgt, step)
//  Sub-module servo_tick_gen (CLK_FREQ_HZ): clk, reset_p -> us_tick. Prescaler only.
//  servo_pwm_core holds: frame counter, shadow registers, slew update, PWM compare register.
// TESTING  (default params, 100 MHz clk)
//  1 enable=1, target=1000, slew=0 -> from 1st period_start: high 100_000 clks, period 2_000_000
//    clks, cur_us=1000, at_target=1.
//  2 target=3000 then target=100 -> cur_us=2500, then 500, each from the next frame; at_target=1.
//  3 cur=1500, target=2000, slew=100 -> cur_us 1600,1700,1800,1900,2000 on 5 successive boundaries;
//    at_target=0 until the 5th boundary, then 1.
//  4 target 1000->2000 written at period_cnt=300 (mid-pulse) -> current pulse stays 1000 us;
//    next frame 2000 us.
//  5 enable 1->0 at period_cnt=200 with cur=1000 -> current pulse still 1000 us; all later frames low.
//    Re-enable -> first pulse only at the next boundary.
//  6 reset_p asserted at period_cnt=400 while high -> servo_pwm=0 the same cycle; cur_us=1500.
//    After release: period_start after exactly 20 ms.

Source files
------------

// File: rtl/servo_pkg.sv
// Shared constants and pulse-width arithmetic for the servo PWM stage.
package servo_pkg;

    localparam int unsigned HZ_PER_MHZ      = 1_000_000;
    localparam int unsigned DEF_CLK_FREQ_HZ = 100_000_000;
    localparam int unsigned DEF_PERIOD_US   = 20000;
    localparam int unsigned DEF_MIN_US      = 500;
    localparam int unsigned DEF_MAX_US      = 2500;
    localparam int unsigned DEF_CENTER_US   = 1500;
    localparam int unsigned DEF_PW_W        = 16;

    function automatic int unsigned clamp_us(int unsigned val, int unsigned lo, int unsigned hi);
        if (val < lo) return lo;
        if (val > hi) return hi;
        return val;
    endfunction

    // Move cur toward tgt by at most step; step of 0 means jump straight to tgt.
    function automatic int unsigned slew_step(int unsigned cur, int unsigned tgt,
                                              int unsigned step);
        int signed   diff;
        int unsigned mag;
        diff = int'(tgt) - int'(cur);
        mag  = (diff < 0) ? int'(-diff) : int'(diff);
        if (step == 0 || mag <= step) return tgt;
        return (diff < 0) ? cur - step : cur + step;
    endfunction

endpackage

// File: rtl/servo_tick_gen.sv
// Prescaler producing a one-clock us_tick once per microsecond.
module servo_tick_gen
    import servo_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = DEF_CLK_FREQ_HZ
) (
    input  logic clk,
    input  logic reset_p,
    output logic us_tick
);

    localparam int unsigned Div  = CLK_FREQ_HZ / HZ_PER_MHZ;
    localparam int unsigned CntW = (Div > 1) ? $clog2(Div) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(Div - 1);

    if ((CLK_FREQ_HZ % HZ_PER_MHZ) != 0 || Div == 0) begin : g_bad_clk
        $error("CLK_FREQ_HZ must be a non-zero multiple of 1 MHz");
    end

    logic [CntW-1:0] pre_cnt_q;

    assign us_tick = (pre_cnt_q == LastCnt);

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            pre_cnt_q <= '0;
        end else if (us_tick) begin
            pre_cnt_q <= '0;
        end else begin
            pre_cnt_q <= pre_cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/servo_pwm_core.sv
// Frame-synchronous servo PWM: shadows enable/target/slew at each frame boundary and drives the pin.
module servo_pwm_core
    import servo_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = DEF_CLK_FREQ_HZ,
    parameter int unsigned PERIOD_US   = DEF_PERIOD_US,
    parameter int unsigned MIN_US      = DEF_MIN_US,
    parameter int unsigned MAX_US      = DEF_MAX_US,
    parameter int unsigned CENTER_US   = DEF_CENTER_US,
    parameter int unsigned PW_W        = DEF_PW_W
) (
    input  logic            clk,
    input  logic            reset_p,
    input  logic            enable,
    input  logic [PW_W-1:0] target_us,
    input  logic [PW_W-1:0] slew_us,
    output logic            servo_pwm,
    output logic [PW_W-1:0] cur_us,
    output logic            at_target,
    output logic            period_start
);

    if (!(MIN_US <= CENTER_US && CENTER_US <= MAX_US && MAX_US < PERIOD_US)) begin : g_bad_range
        $error("Require MIN_US <= CENTER_US <= MAX_US < PERIOD_US");
    end
    if (PW_W > 31 || 64'(PERIOD_US) >= (64'd1 << PW_W)) begin : g_bad_width
        $error("PERIOD_US must fit in PW_W bits and PW_W must be at most 31");
    end

    localparam logic [PW_W-1:0] LastUs   = PW_W'(PERIOD_US - 1);
    localparam logic [PW_W-1:0] CenterUs = PW_W'(CENTER_US);

    logic            us_tick;
    logic            boundary;
    logic [PW_W-1:0] tgt_clamped;
    logic [PW_W-1:0] cur_next;

    logic [PW_W-1:0] period_cnt_q;
    logic [PW_W-1:0] tgt_sh_q;
    logic [PW_W-1:0] cur_q;
    logic            en_sh_q;
    logic            servo_pwm_q;
    logic            period_start_q;

    servo_tick_gen #(
        .CLK_FREQ_HZ(CLK_FREQ_HZ)
    ) u_tick_gen (
        .clk    (clk),
        .reset_p(reset_p),
        .us_tick(us_tick)
    );

    always_comb begin
        boundary    = us_tick && (period_cnt_q == LastUs);
        tgt_clamped = PW_W'(clamp_us(32'(target_us), MIN_US, MAX_US));
        cur_next    = PW_W'(slew_step(32'(cur_q), 32'(tgt_clamped), 32'(slew_us)));
    end

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            period_cnt_q   <= '0;
            tgt_sh_q       <= CenterUs;
            cur_q          <= CenterUs;
            en_sh_q        <= 1'b0;
            servo_pwm_q    <= 1'b0;
            period_start_q <= 1'b0;
        end else begin
            period_start_q <= boundary;
            // Compares against the pre-boundary shadows, so a pulse always finishes its frame.
            servo_pwm_q    <= en_sh_q && (period_cnt_q < cur_q);
            if (us_tick) begin
                period_cnt_q <= boundary ? '0 : period_cnt_q + 1'b1;
            end
            if (boundary) begin
                en_sh_q  <= enable;
                tgt_sh_q <= tgt_clamped;
                cur_q    <= cur_next;
            end
        end
    end

    assign servo_pwm    = servo_pwm_q;
    assign cur_us       = cur_q;
    assign at_target    = (cur_q == tgt_sh_q);
    assign period_start = period_start_q;

endmodule

// File: tb/tb_servo_pwm_core.sv
// Scaled-down bench (2 MHz clk, 40 us frame): per-cycle frame-arithmetic model plus directed checks.
module tb_servo_pwm_core;

    localparam int unsigned CLKHZ = 2_000_000;
    localparam int unsigned DIV   = 2;
    localparam int unsigned PER   = 40;
    localparam int unsigned MINU  = 8;
    localparam int unsigned MAXU  = 30;
    localparam int unsigned CEN   = 15;
    localparam int unsigned PW    = 8;
    localparam int unsigned FRAME = DIV * PER;

    logic          clk = 1'b0;
    logic          reset_p = 1'b1;
    logic          enable = 1'b0;
    logic [PW-1:0] target_us = 8'd15;
    logic [PW-1:0] slew_us = 8'd0;
    logic          servo_pwm;
    logic [PW-1:0] cur_us;
    logic          at_target;
    logic          period_start;

    int n_vec = 0;
    int n_err = 0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    servo_pwm_core #(
        .CLK_FREQ_HZ(CLKHZ),
        .PERIOD_US  (PER),
        .MIN_US     (MINU),
        .MAX_US     (MAXU),
        .CENTER_US  (CEN),
        .PW_W       (PW)
    ) dut (
        .clk         (clk),
        .reset_p     (reset_p),
        .enable      (enable),
        .target_us   (target_us),
        .slew_us     (slew_us),
        .servo_pwm   (servo_pwm),
        .cur_us      (cur_us),
        .at_target   (at_target),
        .period_start(period_start)
    );

    function automatic int unsigned m_clamp(int unsigned v);
        return (v < MINU) ? MINU : ((v > MAXU) ? MAXU : v);
    endfunction

    function automatic int unsigned m_slew(int unsigned cur, int unsigned tgt, int unsigned s);
        int unsigned gap;
        if (s == 0) return tgt;
        if (tgt >= cur) begin
            gap = tgt - cur;
            return cur + ((gap < s) ? gap : s);
        end
        gap = cur - tgt;
        return cur - ((gap < s) ? gap : s);
    endfunction

    // Model: mk = clock edges since reset release; frame boundaries fall on every FRAME-th edge.
    int unsigned mk;
    logic        m_en;
    int unsigned m_tgt;
    int unsigned m_cur;
    logic        m_pwm;
    logic        m_ps;

    always @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            mk    <= 0;
            m_en  <= 1'b0;
            m_tgt <= CEN;
            m_cur <= CEN;
            m_pwm <= 1'b0;
            m_ps  <= 1'b0;
        end else begin
            m_pwm <= m_en && (((mk / DIV) % PER) < m_cur);
            mk    <= mk + 1;
            m_ps  <= ((mk + 1) % FRAME) == 0;
            if (((mk + 1) % FRAME) == 0) begin
                m_en  <= enable;
                m_tgt <= m_clamp(32'(target_us));
                m_cur <= m_slew(m_cur, m_clamp(32'(target_us)), 32'(slew_us));
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            n_vec++;
            if (servo_pwm !== m_pwm || cur_us !== PW'(m_cur) || at_target !== (m_cur == m_tgt)
                || period_start !== m_ps) begin
                n_err++;
                $display("FAIL cycle_cmp t=%0t pwm/cur/at/ps got %b/%0d/%b/%b expected %b/%0d/%b/%b",
                         $time, servo_pwm, cur_us, at_target, period_start,
                         m_pwm, m_cur, (m_cur == m_tgt), m_ps);
            end
        end
    end

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_ps(output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (period_start !== 1'b1 && cycles < 300);
        chk("period_start_seen", 32'(period_start), 1);
    endtask

    // Starts at a period_start negedge; counts high clocks until the next one.
    task automatic measure(input int chg_at, input logic chg_en, input int unsigned chg_tgt,
                           output int high, output int len);
        high = 0;
        len  = 0;
        do begin
            @(negedge clk);
            len++;
            if (servo_pwm === 1'b1) high++;
            if (len == chg_at) begin
                enable    = chg_en;
                target_us = PW'(chg_tgt);
            end
        end while (period_start !== 1'b1 && len < 300);
        chk("frame_len", 32'(len), FRAME);
    endtask

    int n;
    int hi;
    int ln;

    initial begin
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        chk("rst_pwm", 32'(servo_pwm), 0);
        chk("rst_cur", 32'(cur_us), 15);
        chk("rst_at", 32'(at_target), 1);
        chk("rst_ps", 32'(period_start), 0);
        @(negedge clk);
        reset_p = 1'b0;

        // Enable with slew 0: first pulse only after the first boundary.
        enable = 1'b1; target_us = 8'd20; slew_us = 8'd0;
        wait_ps(n);
        chk("first_ps_latency", 32'(n), 80);
        chk("t1_cur", 32'(cur_us), 20);
        chk("t1_at", 32'(at_target), 1);
        measure(-1, 1'b1, 20, hi, ln);
        chk("t1_high", 32'(hi), 40);

        // Clamping above and below.
        target_us = 8'd200;
        wait_ps(n);
        chk("clamp_hi_cur", 32'(cur_us), 30);
        chk("clamp_hi_at", 32'(at_target), 1);
        target_us = 8'd3;
        wait_ps(n);
        chk("clamp_lo_cur", 32'(cur_us), 8);
        chk("clamp_lo_at", 32'(at_target), 1);

        // Slew of 1 us per frame from 15 to 20.
        target_us = 8'd15;
        wait_ps(n);
        target_us = 8'd20; slew_us = 8'd1;
        for (int i = 1; i <= 5; i++) begin
            wait_ps(n);
            chk("slew_cur", 32'(cur_us), 15 + i);
            chk("slew_at", 32'(at_target), (i == 5) ? 1 : 0);
        end

        // Target change mid-pulse takes effect only next frame.
        slew_us = 8'd0; target_us = 8'd10;
        wait_ps(n);
        measure(6, 1'b1, 20, hi, ln);
        chk("midchg_high", 32'(hi), 20);
        chk("midchg_cur", 32'(cur_us), 20);
        measure(-1, 1'b1, 20, hi, ln);
        chk("midchg_next_high", 32'(hi), 40);

        // Disable mid-pulse, then re-enable mid-frame.
        target_us = 8'd10;
        wait_ps(n);
        measure(4, 1'b0, 10, hi, ln);
        chk("dis_cur_frame_high", 32'(hi), 20);
        measure(-1, 1'b0, 10, hi, ln);
        chk("dis_next_high", 32'(hi), 0);
        measure(10, 1'b1, 10, hi, ln);
        chk("reen_same_frame_high", 32'(hi), 0);
        measure(-1, 1'b1, 10, hi, ln);
        chk("reen_next_high", 32'(hi), 20);

        // Random traffic; the compare process checks every cycle.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 24) == 0) begin
                case ($urandom_range(0, 2))
                    0: enable = ($urandom_range(0, 3) != 0);
                    1: target_us = 8'($urandom_range(0, 255));
                    default: slew_us = ($urandom_range(0, 2) == 0) ? 8'd0
                                                                  : 8'($urandom_range(1, 6));
                endcase
            end
        end

        // Reset while the pin is high.
        enable = 1'b1; target_us = 8'd20; slew_us = 8'd0;
        wait_ps(n);
        wait_ps(n);
        repeat (8) @(negedge clk);
        chk("pre_rst_pwm", 32'(servo_pwm), 1);
        #2 reset_p = 1'b1;
        #1;
        chk("rst_mid_pwm", 32'(servo_pwm), 0);
        chk("rst_mid_cur", 32'(cur_us), 15);
        chk("rst_mid_at", 32'(at_target), 1);
        repeat (3) @(negedge clk);
        reset_p = 1'b0;
        wait_ps(n);
        chk("post_rst_ps_latency", 32'(n), 80);
        chk("post_rst_cur", 32'(cur_us), 20);

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
